serial_adder: RTL

Bit-serial WIDTH-bit adder built around the team's existing `one_bit_full_adder` cell. It accepts two parallel operands plus a carry-in, then feeds the full adder one bit pair per clock, LSB first, with the carry held in a flip-flop. It returns a parallel WIDTH-bit sum and carry-out with a done pulse. It sits directly upstream of the full adder and is its only driver and consumer.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/one_bit_full_adder.sv | 13 +
 rtl/serial_adder.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding shared by the bit-serial adder
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/one_bit_full_adder.sv
// rtl/one_bit_full_adder.sv - single-bit combinational full adder cell
module one_bit_full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic Sum
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
// around a single full adder cell with the carry held in a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  one_bit_full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry_q),
    .Cout (fa_cout),
    .Sum  (fa_sum)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are only written on the final RUN edge so they hold across IDLE
  // and through the following operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= A;
            b_sh    <= B;
            carry_q <= Cin;
            cnt     <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry_q <= fa_cout;
          if (last_bit) begin
            Sum  <= {fa_sum, sum_sh[WIDTH-1:1]};
            Cout <= fa_cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
